// File: rtl/led_7seg_out_periph_pkg.sv
`default_nettype none
// ============================================================================
// Package : periph_out_pkg
// Brief   : Shared types and constants for the LED / 7-segment output
//           peripheral: register address map, scan digit states, blank
//           pattern and the active-low hex segment table.
// Revision: 1.0 - initial release
// ============================================================================
package periph_out_pkg;

  // Register address map; address 3 is unmapped.
  typedef enum logic [1:0] {
    ADDR_LED  = 2'd0,
    ADDR_HEX  = 2'd1,
    ADDR_CTRL = 2'd2
  } addr_e;

  // Scan states are the digit indices themselves. Only DIG0..DIG(N-1) are
  // visited for a given digit count.
  typedef enum logic [2:0] {
    DIG0 = 3'd0,
    DIG1 = 3'd1,
    DIG2 = 3'd2,
    DIG3 = 3'd3,
    DIG4 = 3'd4,
    DIG5 = 3'd5,
    DIG6 = 3'd6,
    DIG7 = 3'd7
  } dig_e;

  // All segments off (active low), bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns for 0-9, A, b, C, d, E, F.
  localparam logic [6:0] c_seg_table [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return c_seg_table[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_7seg_out_periph_if.sv
`default_nettype none
// ============================================================================
// Interface: led_7seg_out_periph_if
// Brief    : CPU peripheral bus slice for the output peripheral.
//            we_i   - write strobe, one cycle per write
//            addr_i - register select (0=LED, 1=HEX, 2=CTRL, 3=unmapped)
//            data_i - write data
//            data_o - registered readback of the register at addr_i
//            master: the CPU side; slave: the peripheral.
// Revision : 1.0 - initial release
// ============================================================================
interface led_7seg_out_periph_if;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output we_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  we_i,
    input  addr_i,
    input  data_i,
    output data_o
  );
endinterface
`default_nettype wire

// File: rtl/led_7seg_out_periph_hex7seg_dec.sv
`default_nettype none
// ============================================================================
// Module  : hex7seg_dec
// Brief   : Purely combinational hex nibble to active-low 7-segment decoder.
//           i_nibble - 4-bit value 0..F
//           o_seg    - segments {g,f,e,d,c,b,a}, active low
// Revision: 1.0 - initial release
// ============================================================================
module hex7seg_dec
  import periph_out_pkg::*;
(
  input  wire logic [3:0] i_nibble,
  output logic      [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule
`default_nettype wire

// File: rtl/led_7seg_out_periph.sv
`default_nettype none
// ============================================================================
// Module  : led_7seg_out_periph
// Brief   : Memory-mapped output peripheral. Holds an LED register, a hex
//           value for a multiplexed 7-segment display and a control word
//           (digit enable mask in [7:0], decimal point mask in [15:8]).
//           A refresh counter steps the digit index; display outputs are
//           registered from the current index, so they lag it by one cycle.
// Ports   : clk_i  - system clock
//           rst_i  - synchronous active-high reset
//           bus    - peripheral bus (slave modport): we_i/addr_i/data_i/data_o
//           led_o  - LED drive, active high
//           an_o   - digit anodes, active low, one-hot
//           seg_o  - segments {g,f,e,d,c,b,a}, active low
//           dp_o   - decimal point, active low
// Revision: 1.0 - initial release
// ============================================================================
module led_7seg_out_periph
  import periph_out_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int N_DIGITS    = 4
) (
  input  wire logic                clk_i,
  input  wire logic                rst_i,
  led_7seg_out_periph_if.slave     bus,
  output logic [15:0]              led_o,
  output logic [N_DIGITS-1:0]      an_o,
  output logic [6:0]               seg_o,
  output logic                     dp_o
);

  localparam int                 c_cnt_w    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam int                 c_hex_w    = 4 * N_DIGITS;
  localparam dig_e               c_dig_last = dig_e'(3'(N_DIGITS - 1));

  logic [15:0]          r_led;
  logic [c_hex_w-1:0]   r_hex;
  logic [N_DIGITS-1:0]  r_en;
  logic [N_DIGITS-1:0]  r_dpm;
  logic [31:0]          r_rdata;
  logic [c_cnt_w-1:0]   r_cnt;
  dig_e                 r_idx;
  logic [N_DIGITS-1:0]  r_an;
  logic [6:0]           r_seg;
  logic                 r_dp;

  // Masks widened to 8 bits so they can be indexed by the 3-bit digit index
  // for any legal digit count.
  logic [7:0]  w_en8;
  logic [7:0]  w_dp8;
  logic [7:0]  w_an8;
  logic [31:0] w_hex32;
  logic [3:0]  w_nibble;
  logic [6:0]  w_seg;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_en8    = 8'(r_en);
  assign w_dp8    = 8'(r_dpm);
  assign w_an8    = ~(8'd1 << r_idx);
  assign w_hex32  = 32'(r_hex);
  assign w_nibble = w_hex32[{r_idx, 2'b00} +: 4];
  assign w_unused = ^bus.data_i;

  hex7seg_dec u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_comb begin
    w_rdata = '0;
    case (bus.addr_i)
      ADDR_LED:  w_rdata = {16'h0000, r_led};
      ADDR_HEX:  w_rdata = w_hex32;
      ADDR_CTRL: w_rdata = {16'h0000, w_dp8, w_en8};
      default:   w_rdata = '0;
    endcase
  end

  // Registers, refresh counter, scan state and output registers. The read
  // mux samples pre-write register values, so a same-cycle write and read of
  // one address returns the old value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_led   <= '0;
      r_hex   <= '0;
      r_en    <= '0;
      r_dpm   <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_idx   <= DIG0;
      r_an    <= '1;
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b1;
    end else begin
      if (bus.we_i) begin
        case (bus.addr_i)
          ADDR_LED:  r_led <= bus.data_i[15:0];
          ADDR_HEX:  r_hex <= bus.data_i[c_hex_w-1:0];
          ADDR_CTRL: begin
            r_en  <= bus.data_i[N_DIGITS-1:0];
            r_dpm <= bus.data_i[8 +: N_DIGITS];
          end
          default: ;
        endcase
      end

      r_rdata <= w_rdata;

      if (r_cnt == c_cnt_last) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_dig_last) ? DIG0 : dig_e'(r_idx + 3'd1);
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end

      if (w_en8[r_idx]) begin
        r_an  <= w_an8[N_DIGITS-1:0];
        r_seg <= w_seg;
        r_dp  <= ~w_dp8[r_idx];
      end else begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b1;
      end
    end
  end

  assign led_o       = r_led;
  assign an_o        = r_an;
  assign seg_o       = r_seg;
  assign dp_o        = r_dp;
  assign bus.data_o  = r_rdata;

endmodule
`default_nettype wire
